// File: rtl/cpu_wb_pkg.sv
// Shared definitions for the CPU-to-Wishbone bridge.
//   state_e              : bridge FSM states (idle, bus cycle open, completion)
//   DefaultDw, DefaultAw : default data/address bus widths
//   DefaultTimeoutCycles : default bus timeout, used only when
//                          CPU_WB_BRIDGE_TIMEOUT_EN is defined
package cpu_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StDone
  } state_e;

  localparam int unsigned DefaultDw            = 32;
  localparam int unsigned DefaultAw            = 32;
  localparam int unsigned DefaultTimeoutCycles = 256;

endpackage

// File: rtl/cpu_wb_bridge.sv
// Single-transfer Wishbone classic master driven by the flat CPU request bus
// from packet_decode. Each accepted cpu_start issues exactly one
// non-pipelined Wishbone cycle. All outputs come straight from flops.
//
// Configuration macro: CPU_WB_BRIDGE_TIMEOUT_EN
//   defined   : a BUS-state counter aborts the cycle after TIMEOUT_CYCLES
//               cycles without ack/err, reporting it as an error.
//   undefined : the bridge waits indefinitely for ack/err.
//
// Ports:
//   wb_clk, wb_rst_n     clock, asynchronous active-low reset
//   cpu_start            request strobe, sampled in idle only
//   cpu_address/selection/write/data_wr  request fields, latched on accept
//   cpu_data_rd          last completed read data
//   cpu_active           high from accept until completion
//   cpu_error            sticky status of the last transfer (err or timeout)
//   wb_*_o / wb_*_i      Wishbone classic master interface
module cpu_wb_bridge
  import cpu_wb_pkg::*;
#(
  parameter int unsigned DW             = DefaultDw,
  parameter int unsigned AW             = DefaultAw,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  // CPU request side
  input  logic            cpu_start,
  input  logic [AW-1:0]   cpu_address,
  input  logic [DW/8-1:0] cpu_selection,
  input  logic            cpu_write,
  input  logic [DW-1:0]   cpu_data_wr,
  output logic [DW-1:0]   cpu_data_rd,
  output logic            cpu_active,
  output logic            cpu_error,
  // Wishbone master side
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  state_e              state_q, state_d;
  logic   [AW-1:0]     adr_q, adr_d;
  logic   [DW-1:0]     dat_q, dat_d;
  logic   [DW/8-1:0]   sel_q, sel_d;
  logic                we_q, we_d;
  logic                cyc_q, cyc_d;
  logic                active_q, active_d;
  logic                error_q, error_d;
  logic   [DW-1:0]     rd_q, rd_d;
  logic                timeout;

`ifdef CPU_WB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Cleared whenever we are not in BUS, so it starts from zero on entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == StBus) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    cyc_d    = cyc_q;
    active_d = active_q;
    error_d  = error_q;
    rd_d     = rd_q;

    unique case (state_q)
      StIdle: begin
        if (cpu_start) begin
          adr_d    = cpu_address;
          dat_d    = cpu_data_wr;
          sel_d    = cpu_selection;
          we_d     = cpu_write;
          cyc_d    = 1'b1;
          active_d = 1'b1;
          error_d  = 1'b0;
          state_d  = StBus;
        end
      end
      StBus: begin
        // err takes priority over a simultaneous ack; read data is dropped.
        if (wb_err_i || timeout) begin
          cyc_d    = 1'b0;
          active_d = 1'b0;
          error_d  = 1'b1;
          state_d  = StDone;
        end else if (wb_ack_i) begin
          cyc_d    = 1'b0;
          active_d = 1'b0;
          if (!we_q) begin
            rd_d = wb_dat_i;
          end
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d  = StIdle;
        cyc_d    = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= StIdle;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      cyc_q    <= cyc_d;
      active_q <= active_d;
      error_q  <= error_d;
      rd_q     <= rd_d;
    end
  end

  // Classic single transfers: stb always tracks cyc.
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign cpu_active  = active_q;
  assign cpu_error   = error_q;
  assign cpu_data_rd = rd_q;

endmodule
